// File: rtl/stream_accumulator43_7.sv
// stream_accumulator43_7
// Folds a stream of 7-bit unsigned increments into a 43-bit running total.
// Each run starts from a programmed value and lasts SAMPLE_COUNT accepted beats.
// A carry-out from any beat clamps the total to all ones and sets a sticky overflow flag.
// The finished total is handed to the consumer over a valid/ready handshake.
module stream_accumulator43_7 #(
    parameter int SAMPLE_COUNT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [42:0] init_value,
    input  logic        in_valid,
    input  logic [6:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [42:0] out_sum,
    output logic        overflow,
    output logic        busy
);

    localparam int ACC_W  = 43;
    localparam int DATA_W = 7;
    localparam int CNT_W  = 16;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(SAMPLE_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  beat_cnt;
    logic              ovf;
    logic [ACC_W:0]    sat_sum;

    // Widened add; bit ACC_W of the result carries the "saturated" indication
    // and the low bits hold the clamped total.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        logic [ACC_W:0] sum44;
        sum44 = {1'b0, a} + {{(ACC_W-DATA_W+1){1'b0}}, b};
        if (sum44[ACC_W])
            return {1'b1, {ACC_W{1'b1}}};
        else
            return {1'b0, sum44[ACC_W-1:0]};
    endfunction

    // Saturating sum of the current total and the incoming increment.
    always_comb begin
        sat_sum = sat_add(acc, in_data);
    end

    // Run control, beat counting and accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            beat_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= init_value;
                        beat_cnt <= '0;
                        ovf      <= 1'b0;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc      <= sat_sum[ACC_W-1:0];
                        beat_cnt <= beat_cnt + 16'd1;
                        if (sat_sum[ACC_W])
                            ovf <= 1'b1;
                        if (beat_cnt == LAST_BEAT)
                            state <= DONE;
                    end
                end
                DONE: begin
                    // Total and flag are frozen here; start is ignored.
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and status outputs decode directly from the registered state,
    // so in_ready never depends on in_valid.
    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        out_sum   = acc;
        overflow  = ovf;
    end

endmodule
